alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Operand-read and issue stage directly upstream of the integer ALU.
- Buffers decoded micro-ops in a small FIFO, reads the architectural register file, and resolves read-after-write hazards against the op in flight using a one-cycle bubble plus the ALU result forwarding bus.
- Drives the ALU's micro-op, two operands and destination address from registered outputs.

Parameters:
- WIDTH_ALU, 32, operand/result width.
- MOP_W, 8, micro-op code width; must match the ALU micro-op field.
- DEPTH, 4, decoded-op FIFO entries; power of two, minimum 2.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rest  in  1  reset; asynchronous, active-low.
- Flush  in  1  branch/exception flush; synchronous, active-high.
- DecValid  in  1  decode offers an op.
- DecReady  out  1  stage accepts an op.
- DecMicOp  in  MOP_W  micro-op code.
- DecSrc1Addr  in  5  source register 1 index.
- DecSrc2Addr  in  5  source register 2 index.
- DecImm  in  WIDTH_ALU  pre-extended immediate.
- DecImmSel  in  2  operand source: 0 = reg/reg; 1 = immediate replaces operand2; 2 = immediate replaces operand1 (lu12i.w); 3 = reserved, treated as 0.
- DecDestAddr  in  5  destination register.
- DecDestEn  in  1  op writes a register.
- RfRaddr1  out  5  register file read address 1 (combinational from FIFO head).
- RfRaddr2  out  5  register file read address 2 (combinational from FIFO head).
- RfRdata1  in  WIDTH_ALU  register file data 1, combinational read.
- RfRdata2  in  WIDTH_ALU  register file data 2, combinational read.
- FwdValid  in  1  ALU result bus valid.
- FwdAddr  in  5  ALU result destination.
- FwdData  in  WIDTH_ALU  ALU result.
- AluReady  in  1  downstream can take a new op.
- IssueValid  out  1  issue register holds a valid op.
- AluMicOperate  out  MOP_W  issued micro-op.
- ArchRegister1  out  WIDTH_ALU  operand 1.
- ArchRegister2  out  WIDTH_ALU  operand 2.
- ReDataAddr  out  5  issued destination; 0 when DecDestEn was 0.

Behaviour:
- Reset (Rest low, async): FIFO empty, pointers/count 0; IssueValid, AluMicOperate, ArchRegister1/2 and ReDataAddr all 0. DecReady is 1 once reset is released.
- FIFO:
  - Push on DecValid && DecReady.
  - DecReady = (count < DEPTH) && !Flush. When full, DecReady = 0 even if a pop occurs that cycle (no pass-through).
  - Pointers wrap modulo DEPTH. Simultaneous push and pop when not full leaves count unchanged.
- Operand resolve, per source, highest priority first:
  1. Index 0 gives 0.
  2. FwdValid && FwdAddr == index gives FwdData.
  3. Otherwise RfRdata.
  - DecImmSel then overrides the selected operand with DecImm.
- Hazard: the head uses source index s ≠ 0, with that source not replaced by the immediate, and IssueValid && ReDataAddr == s. Any such match is a hazard.
- Issue decision each edge, with Flush having absolute priority:
  - Flush = 1: FIFO cleared; IssueValid ← 0; other outputs hold.
  - Else if !AluReady: issue register holds all values; no pop.
  - Else if FIFO non-empty and no hazard: pop head; load outputs; IssueValid ← 1. Latency from push into an empty FIFO to IssueValid is 1 cycle.
  - Else: bubble. IssueValid ← 0; outputs hold their old values; no pop.
- Dependent back-to-back ops therefore issue with exactly one bubble. During the bubble cycle the ALU result appears on Fwd* and is captured.
- Throughput: one op per cycle for independent ops.
- Reset asserted mid-operation discards every queued and in-flight op immediately.

Test Plan:
- Reset then three independent pushes (addw r3=r1+r2 with RF r1=5, r2=7; slt; subw) with AluReady = 1 -> IssueValid high for 3 consecutive cycles; first issue has ArchRegister1 = 5, ArchRegister2 = 7, ReDataAddr = 3.
- addw r4←r1,r2 then addw r5←r4,r1, with FwdValid/FwdAddr = 4/FwdData = 12 presented in the cycle after the first issue -> one IssueValid = 0 bubble; second issue has ArchRegister1 = 12, not the stale RF value 99.
- Fill DEPTH = 4 with AluReady = 0 -> DecReady = 0 with count 4. Fifth DecValid is not accepted; issue outputs stay constant. Raising AluReady drains in order with a 0/1/2/3 pointer wrap.
- DecImmSel = 2, DecImm = 0x12345000, Src1 = 9 with a pending writer to r9 -> no hazard bubble; ArchRegister1 = 0x12345000. Source index 0 with FwdAddr = 0, FwdData = 0xFFFFFFFF -> operand = 0.
- Flush asserted with 3 queued ops and IssueValid = 1 -> next cycle IssueValid = 0, FIFO empty; DecValid during the flush cycle is dropped.
- Rest pulsed low asynchronously mid-stream (between clock edges) -> all outputs 0 immediately; first push after release issues normally.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Generic decoded-op FIFO: registered storage, power-of-two depth, synchronous clear.
// Latency: a pushed entry is visible at head_dat_o the cycle after the push edge.
// Backpressure: full_o blocks push (no pass-through when full); empty_o blocks pop.
module alu_issue_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] head_dat_o,
    output logic         empty_o,
    output logic         full_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty_o    = (cnt_q == '0);
    assign full_o     = (cnt_q == CW'(DEPTH));
    assign head_dat_o = mem_q[rptr_q];
    assign do_push    = push_i && !full_o && !clr_i;
    assign do_pop     = pop_i && !empty_o && !clr_i;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wptr_d = wptr_q + AW'(1);
            if (do_pop)  rptr_d = rptr_q + AW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= push_dat_i;
    end
endmodule

// ALU operand-read/issue stage: queues decoded ops, resolves operands, stalls on RAW vs in-flight op.
// Latency: 1 cycle from push into an empty queue to issue_vld_o; one bubble for a dependent op.
// Backpressure: dec_rdy_o drops when queue full or flushing; alu_rdy_i low freezes the issue register.
module alu_issue_stage #(
    parameter int WIDTH_ALU = 32,
    parameter int MOP_W     = 8,
    parameter int DEPTH     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 dec_vld_i,
    output logic                 dec_rdy_o,
    input  logic [MOP_W-1:0]     dec_mop_i,
    input  logic [4:0]           dec_src1_i,
    input  logic [4:0]           dec_src2_i,
    input  logic [WIDTH_ALU-1:0] dec_imm_i,
    input  logic [1:0]           dec_imm_sel_i,
    input  logic [4:0]           dec_dest_i,
    input  logic                 dec_dest_en_i,
    output logic [4:0]           rf_raddr1_o,
    output logic [4:0]           rf_raddr2_o,
    input  logic [WIDTH_ALU-1:0] rf_rdata1_i,
    input  logic [WIDTH_ALU-1:0] rf_rdata2_i,
    input  logic                 fwd_vld_i,
    input  logic [4:0]           fwd_addr_i,
    input  logic [WIDTH_ALU-1:0] fwd_dat_i,
    input  logic                 alu_rdy_i,
    output logic                 issue_vld_o,
    output logic [MOP_W-1:0]     alu_mop_o,
    output logic [WIDTH_ALU-1:0] alu_op1_o,
    output logic [WIDTH_ALU-1:0] alu_op2_o,
    output logic [4:0]           alu_dest_o
);
    typedef struct packed {
        logic [MOP_W-1:0]     mop;
        logic [4:0]           src1;
        logic [4:0]           src2;
        logic [WIDTH_ALU-1:0] imm;
        logic [1:0]           imm_sel;
        logic [4:0]           dest;
        logic                 dest_en;
    } uop_t;

    localparam int UW = $bits(uop_t);

    uop_t          dec_uop, head;
    logic [UW-1:0] head_vec;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    logic                 issue_vld_q, issue_vld_d;
    logic [MOP_W-1:0]     mop_q, mop_d;
    logic [WIDTH_ALU-1:0] op1_q, op1_d;
    logic [WIDTH_ALU-1:0] op2_q, op2_d;
    logic [4:0]           dest_q, dest_d;

    logic                 use1, use2, hazard;
    logic [WIDTH_ALU-1:0] src1_val, src2_val;

    function automatic logic [WIDTH_ALU-1:0] resolve(
        input logic [4:0]           idx,
        input logic [WIDTH_ALU-1:0] rf_dat,
        input logic                 fv,
        input logic [4:0]           fa,
        input logic [WIDTH_ALU-1:0] fd
    );
        if (idx == 5'd0)            return '0;
        else if (fv && (fa == idx)) return fd;
        else                        return rf_dat;
    endfunction

    assign dec_uop = '{mop: dec_mop_i, src1: dec_src1_i, src2: dec_src2_i, imm: dec_imm_i,
                       imm_sel: dec_imm_sel_i, dest: dec_dest_i, dest_en: dec_dest_en_i};

    assign dec_rdy_o = !fifo_full && !flush_i;
    assign push      = dec_vld_i && dec_rdy_o;

    alu_issue_fifo #(.W(UW), .DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (flush_i),
        .push_i     (push),
        .push_dat_i (dec_uop),
        .pop_i      (pop),
        .head_dat_o (head_vec),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full)
    );

    assign head        = uop_t'(head_vec);
    assign rf_raddr1_o = head.src1;
    assign rf_raddr2_o = head.src2;

    assign src1_val = resolve(head.src1, rf_rdata1_i, fwd_vld_i, fwd_addr_i, fwd_dat_i);
    assign src2_val = resolve(head.src2, rf_rdata2_i, fwd_vld_i, fwd_addr_i, fwd_dat_i);

    // A source swapped out for the immediate cannot create a dependency.
    assign use1   = (head.imm_sel != 2'd2);
    assign use2   = (head.imm_sel != 2'd1);
    assign hazard = issue_vld_q &&
                    ((use1 && (head.src1 != 5'd0) && (dest_q == head.src1)) ||
                     (use2 && (head.src2 != 5'd0) && (dest_q == head.src2)));

    always_comb begin
        issue_vld_d = issue_vld_q;
        mop_d       = mop_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        dest_d      = dest_q;
        pop         = 1'b0;
        if (flush_i) begin
            issue_vld_d = 1'b0;
        end else if (alu_rdy_i) begin
            if (!fifo_empty && !hazard) begin
                pop         = 1'b1;
                issue_vld_d = 1'b1;
                mop_d       = head.mop;
                op1_d       = (head.imm_sel == 2'd2) ? head.imm : src1_val;
                op2_d       = (head.imm_sel == 2'd1) ? head.imm : src2_val;
                dest_d      = head.dest_en ? head.dest : 5'd0;
            end else begin
                issue_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issue_vld_q <= 1'b0;
            mop_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            dest_q      <= '0;
        end else begin
            issue_vld_q <= issue_vld_d;
            mop_q       <= mop_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            dest_q      <= dest_d;
        end
    end

    assign issue_vld_o = issue_vld_q;
    assign alu_mop_o   = mop_q;
    assign alu_op1_o   = op1_q;
    assign alu_op2_o   = op2_q;
    assign alu_dest_o  = dest_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: vector table, directed corner sequences, randomized run vs queue model.
module tb_alu_issue_stage;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0]  mop;
        logic [4:0]  s1;
        logic [4:0]  s2;
        logic [31:0] imm;
        logic [1:0]  sel;
        logic [4:0]  dest;
        logic        den;
    } op_t;

    typedef struct {
        op_t         op;
        logic        fv;
        logic [4:0]  fa;
        logic [31:0] fd;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [4:0]  ed;
    } vec_t;

    logic        clk, rst_n, flush, dec_vld, dec_rdy, den, fwd_vld, alu_rdy, issue_vld;
    logic [7:0]  dec_mop, alu_mop;
    logic [4:0]  s1, s2, dest, raddr1, raddr2, fwd_addr, alu_dest;
    logic [31:0] imm, rdata1, rdata2, fwd_dat, op1, op2;
    logic [1:0]  sel;
    logic [31:0] rf [32];

    int n_tests = 0;
    int n_fail  = 0;

    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

    alu_issue_stage #(.WIDTH_ALU(32), .MOP_W(8), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .dec_vld_i(dec_vld), .dec_rdy_o(dec_rdy), .dec_mop_i(dec_mop),
        .dec_src1_i(s1), .dec_src2_i(s2), .dec_imm_i(imm), .dec_imm_sel_i(sel),
        .dec_dest_i(dest), .dec_dest_en_i(den),
        .rf_raddr1_o(raddr1), .rf_raddr2_o(raddr2), .rf_rdata1_i(rdata1), .rf_rdata2_i(rdata2),
        .fwd_vld_i(fwd_vld), .fwd_addr_i(fwd_addr), .fwd_dat_i(fwd_dat),
        .alu_rdy_i(alu_rdy), .issue_vld_o(issue_vld), .alu_mop_o(alu_mop),
        .alu_op1_o(op1), .alu_op2_o(op2), .alu_dest_o(alu_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [7:0] m, input logic [4:0] a, input logic [4:0] b,
                               input logic [31:0] im, input logic [1:0] se,
                               input logic [4:0] d, input logic de);
        op_t o;
        o.mop = m; o.s1 = a; o.s2 = b; o.imm = im; o.sel = se; o.dest = d; o.den = de;
        return o;
    endfunction

    task automatic drive(input op_t o, input logic v);
        dec_mop = o.mop; s1 = o.s1; s2 = o.s2; imm = o.imm; sel = o.sel;
        dest = o.dest; den = o.den; dec_vld = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic chk_issue(input string nm, input logic v, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] d);
        chk({nm, ".vld"},  issue_vld, v);
        chk({nm, ".op1"},  op1, a);
        chk({nm, ".op2"},  op2, b);
        chk({nm, ".dest"}, alu_dest, d);
    endtask

    // Reference model: a queue of pending ops plus the issued op.
    op_t         mq[$];
    logic        m_vld;
    logic [7:0]  m_mop;
    logic [31:0] m_o1, m_o2;
    logic [4:0]  m_dest;

    function automatic logic [31:0] m_src(input logic [4:0] idx);
        if (idx == 0) return 32'd0;
        if (fwd_vld && fwd_addr == idx) return fwd_dat;
        return rf[idx];
    endfunction

    task automatic model_step(input op_t cur);
        op_t  h;
        logic haz, can_push;
        can_push = (mq.size() < DEPTH) && !flush;
        if (flush) begin
            mq.delete();
            m_vld = 1'b0;
        end else if (alu_rdy) begin
            if (mq.size() > 0) begin
                h   = mq[0];
                haz = m_vld && m_dest != 0 &&
                      ((h.sel != 2 && h.s1 == m_dest) || (h.sel != 1 && h.s2 == m_dest));
                if (!haz) begin
                    void'(mq.pop_front());
                    m_vld  = 1'b1;
                    m_mop  = h.mop;
                    m_o1   = (h.sel == 2) ? h.imm : m_src(h.s1);
                    m_o2   = (h.sel == 1) ? h.imm : m_src(h.s2);
                    m_dest = h.den ? h.dest : 5'd0;
                end else begin
                    m_vld = 1'b0;
                end
            end else begin
                m_vld = 1'b0;
            end
        end
        if (dec_vld && can_push) mq.push_back(cur);
    endtask

    vec_t vt[9];
    op_t  o, q2;

    initial begin
        vt[0] = '{mk(8'h01, 1, 2, 0, 0, 3, 1),            0, 0, 0,            5,            7,            3};
        vt[1] = '{mk(8'h02, 0, 2, 0, 0, 6, 1),            1, 0, 32'hFFFFFFFF, 0,            7,            6};
        vt[2] = '{mk(8'h03, 1, 2, 32'h100, 1, 7, 1),      0, 0, 0,            5,            32'h100,      7};
        vt[3] = '{mk(8'h04, 9, 5, 32'h12345000, 2, 8, 1), 0, 0, 0,            32'h12345000, 32'h1005,     8};
        vt[4] = '{mk(8'h05, 1, 2, 32'h55, 3, 9, 1),       0, 0, 0,            5,            7,            9};
        vt[5] = '{mk(8'h06, 3, 2, 0, 0, 10, 1),           1, 2, 32'hABCD,     32'h1003,     32'hABCD,     10};
        vt[6] = '{mk(8'h07, 1, 1, 0, 0, 7, 0),            0, 0, 0,            5,            5,            0};
        vt[7] = '{mk(8'h08, 4, 4, 0, 0, 11, 1),           1, 4, 12,           12,           12,           11};
        vt[8] = '{mk(8'h09, 0, 4, 32'h55, 1, 1, 1),       1, 4, 32'h77,       0,            32'h55,       1};

        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'hDEADBEEF; rf[1] = 5; rf[2] = 7; rf[4] = 99; rf[9] = 32'h900;
        flush = 0; alu_rdy = 1; fwd_vld = 0; fwd_addr = 0; fwd_dat = 0;
        drive(mk(0, 0, 0, 0, 0, 0, 0), 0);
        do_reset();
        chk_issue("reset", 0, 0, 0, 0);
        chk("reset.mop", alu_mop, 0);
        chk("reset.rdy", dec_rdy, 1);

        // Operand-resolution vectors, one op at a time through an idle stage.
        for (int i = 0; i < 9; i++) begin
            drive(vt[i].op, 1);
            tick();
            dec_vld = 0;
            fwd_vld = vt[i].fv; fwd_addr = vt[i].fa; fwd_dat = vt[i].fd;
            #1;
            chk($sformatf("vec%0d.raddr1", i), raddr1, vt[i].op.s1);
            tick();
            chk_issue($sformatf("vec%0d", i), 1, vt[i].e1, vt[i].e2, vt[i].ed);
            chk($sformatf("vec%0d.mop", i), alu_mop, vt[i].op.mop);
            fwd_vld = 0;
            tick();
        end

        // Three independent ops issue on consecutive cycles.
        drive(mk(8'h11, 1, 2, 0, 0, 3, 1), 1); tick();
        drive(mk(8'h12, 1, 2, 0, 0, 6, 1), 1); tick();
        chk_issue("indep0", 1, 5, 7, 3);
        drive(mk(8'h13, 2, 1, 0, 0, 7, 1), 1); tick();
        chk_issue("indep1", 1, 5, 7, 6);
        chk("indep1.mop", alu_mop, 8'h12);
        dec_vld = 0; tick();
        chk_issue("indep2", 1, 7, 5, 7);
        tick();
        chk("indep.end", issue_vld, 0);

        // Dependent pair: one bubble, then forwarded value replaces stale RF.
        drive(mk(8'h21, 1, 2, 0, 0, 4, 1), 1); tick();
        drive(mk(8'h21, 4, 1, 0, 0, 5, 1), 1); tick();
        chk_issue("dep.first", 1, 5, 7, 4);
        dec_vld = 0; fwd_vld = 1; fwd_addr = 4; fwd_dat = 12;
        tick();
        chk("dep.bubble", issue_vld, 0);
        tick();
        chk_issue("dep.second", 1, 12, 5, 5);
        fwd_vld = 0; tick();

        // Fill with ALU stalled, reject fifth op, then drain in order across the wrap.
        do_reset();
        alu_rdy = 0;
        for (int i = 0; i < 4; i++) begin
            drive(mk(8'h30 + 8'(i), 1, 2, 0, 0, 5'(10 + i), 1), 1);
            tick();
        end
        chk("full.rdy", dec_rdy, 0);
        drive(mk(8'h34, 1, 2, 0, 0, 14, 1), 1); tick();
        chk("full.hold_vld", issue_vld, 0);
        chk("full.hold_mop", alu_mop, 0);
        dec_vld = 0; alu_rdy = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_issue($sformatf("drain%0d", i), 1, 5, 7, 5'(10 + i));
            if (i == 0) chk("drain.rdy", dec_rdy, 1);
        end
        tick();
        chk("drain.fifth_dropped", issue_vld, 0);

        // Immediate replaces operand 1: no hazard on r9; index 0 ignores forwarding.
        drive(mk(8'h40, 1, 2, 0, 0, 9, 1), 1); tick();
        drive(mk(8'h41, 9, 0, 32'h12345000, 2, 6, 1), 1);
        fwd_vld = 1; fwd_addr = 0; fwd_dat = 32'hFFFFFFFF;
        tick();
        chk_issue("imm.writer", 1, 5, 7, 9);
        dec_vld = 0; tick();
        chk_issue("imm.nobubble", 1, 32'h12345000, 0, 6);
        fwd_vld = 0; tick();

        // Flush with three queued ops and a valid issue.
        drive(mk(8'h50, 1, 2, 0, 0, 11, 1), 1); tick();
        drive(mk(8'h51, 1, 2, 0, 0, 12, 1), 1); tick();
        alu_rdy = 0;
        drive(mk(8'h52, 1, 2, 0, 0, 13, 1), 1); tick();
        drive(mk(8'h53, 1, 2, 0, 0, 14, 1), 1); tick();
        chk("flush.pre_vld", issue_vld, 1);
        flush = 1;
        drive(mk(8'h54, 1, 2, 0, 0, 15, 1), 1); #1;
        chk("flush.rdy", dec_rdy, 0);
        tick();
        chk("flush.vld", issue_vld, 0);
        chk("flush.dest_hold", alu_dest, 11);
        flush = 0; dec_vld = 0; alu_rdy = 1;
        tick(); chk("flush.empty0", issue_vld, 0);
        tick(); chk("flush.empty1", issue_vld, 0);
        drive(mk(8'h55, 1, 2, 0, 0, 2, 1), 1); tick();
        dec_vld = 0; tick();
        chk_issue("flush.after", 1, 5, 7, 2);

        // Asynchronous reset mid-cycle discards everything.
        drive(mk(8'h60, 1, 2, 0, 0, 3, 1), 1); tick();
        drive(mk(8'h61, 1, 2, 0, 0, 4, 1), 1); tick();
        alu_rdy = 0;
        drive(mk(8'h62, 1, 2, 0, 0, 5, 1), 1); tick();
        dec_vld = 0;
        #2 rst_n = 0;
        #1;
        chk_issue("arst", 0, 0, 0, 0);
        chk("arst.mop", alu_mop, 0);
        #1 rst_n = 1;
        alu_rdy = 1;
        tick(); chk("arst.discard", issue_vld, 0);
        drive(mk(8'h63, 1, 2, 0, 0, 8, 1), 1); tick();
        dec_vld = 0; tick();
        chk_issue("arst.after", 1, 5, 7, 8);

        // Randomized run against the queue model.
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        dec_vld = 0; flush = 0; fwd_vld = 0;
        do_reset();
        mq.delete();
        m_vld = 0; m_mop = 0; m_o1 = 0; m_o2 = 0; m_dest = 0;
        for (int c = 0; c < 3000; c++) begin
            q2 = mk(8'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom,
                    2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            drive(q2, ($urandom_range(0, 4) < 3));
            flush    = ($urandom_range(0, 19) == 0);
            alu_rdy  = ($urandom_range(0, 3) != 0);
            fwd_vld  = 1'($urandom_range(0, 1));
            fwd_addr = 5'($urandom_range(0, 7));
            fwd_dat  = $urandom;
            #1;
            chk("rnd.rdy", dec_rdy, (mq.size() < DEPTH) && !flush);
            if (mq.size() > 0) begin
                o = mq[0];
                chk("rnd.raddr1", raddr1, o.s1);
                chk("rnd.raddr2", raddr2, o.s2);
            end
            model_step(q2);
            tick();
            chk_issue("rnd", m_vld, m_o1, m_o2, m_dest);
            chk("rnd.mop", alu_mop, m_mop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
